// File: rtl/branch_fwd_scoreboard.sv
// rtl/branch_fwd_scoreboard.sv - ID-stage branch operand forwarding/stall unit using an in-flight writer scoreboard
module branch_fwd_scoreboard #(
    parameter int AW         = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int ALU_READY  = 1,
    parameter int LOAD_READY = 2,
    parameter int SW         = 2,
    parameter int CW         = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_hold,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic [AW-1:0]         id_dst,
    input  logic                  id_is_branch,
    input  logic [NUM_SRC*AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]    id_src_used,
    output logic [NUM_SRC*SW-1:0] fwd_sel,
    output logic                  stall,
    output logic [CW-1:0]         stall_cnt,
    output logic [CW-1:0]         fwd_cnt
);

    logic [DEPTH-1:0]         v_q, v_d;
    logic [DEPTH-1:0]         ld_q, ld_d;
    logic [DEPTH-1:0][AW-1:0] dst_q, dst_d;
    logic [CW-1:0]            stall_cnt_q, stall_cnt_d;
    logic [CW-1:0]            fwd_cnt_q, fwd_cnt_d;

    logic [NUM_SRC*SW-1:0]    sel_raw;
    logic                     stall_raw;
    logic [AW-1:0]            src;
    logic                     hit;
    logic                     rdy;
    logic [SW-1:0]            near_sel;
    logic                     active;

    // Per-source nearest-producer search: descending scan so the smallest k wins.
    always_comb begin
        sel_raw   = '0;
        stall_raw = 1'b0;
        src       = '0;
        hit       = 1'b0;
        rdy       = 1'b0;
        near_sel  = '0;
        active    = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src      = id_src[i*AW +: AW];
            hit      = 1'b0;
            rdy      = 1'b0;
            near_sel = '0;
            for (int k = DEPTH-1; k >= 0; k--) begin
                if (v_q[k] && (dst_q[k] != '0) && (dst_q[k] == src)) begin
                    hit      = 1'b1;
                    rdy      = ld_q[k] ? (k >= LOAD_READY) : (k >= ALU_READY);
                    near_sel = SW'(k + 1);
                end
            end
            active = id_is_branch && id_valid && id_src_used[i] && hit;
            if (active && rdy)
                sel_raw[i*SW +: SW] = near_sel;
            if (active && !rdy)
                stall_raw = 1'b1;
        end
    end

    assign stall     = stall_raw && !flush;
    assign fwd_sel   = stall ? '0 : sel_raw;
    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;

    always_comb begin
        v_d         = v_q;
        ld_d        = ld_q;
        dst_d       = dst_q;
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (!pipe_hold) begin
            for (int k = 1; k < DEPTH; k++) begin
                v_d[k]   = v_q[k-1];
                ld_d[k]  = ld_q[k-1];
                dst_d[k] = dst_q[k-1];
            end
            // Stalled or squashed ID instructions enter EX as bubbles.
            v_d[0]   = id_valid && id_regwrite && !stall && !flush;
            ld_d[0]  = id_memread;
            dst_d[0] = id_dst;
            if (stall && (stall_cnt_q != '1))
                stall_cnt_d = stall_cnt_q + 1'b1;
            if (!stall && (fwd_sel != '0) && (fwd_cnt_q != '1))
                fwd_cnt_d = fwd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q         <= '0;
            ld_q        <= '0;
            dst_q       <= '0;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            v_q         <= v_d;
            ld_q        <= ld_d;
            dst_q       <= dst_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_fwd_scoreboard.sv
// tb/tb_branch_fwd_scoreboard.sv - directed self-checking bench for branch_fwd_scoreboard
module tb_branch_fwd_scoreboard;

    localparam int AW = 5;
    localparam int NS = 2;
    localparam int SW = 2;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           pipe_hold;
    logic           flush;
    logic           id_valid;
    logic           id_regwrite;
    logic           id_memread;
    logic [AW-1:0]  id_dst;
    logic           id_is_branch;
    logic [NS*AW-1:0] id_src;
    logic [NS-1:0]  id_src_used;
    logic [NS*SW-1:0] fwd_sel;
    logic           stall;
    logic [CW-1:0]  stall_cnt;
    logic [CW-1:0]  fwd_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_fwd_scoreboard #(
        .AW(AW), .NUM_SRC(NS), .DEPTH(3), .ALU_READY(1), .LOAD_READY(2), .SW(SW), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pipe_hold(pipe_hold), .flush(flush),
        .id_valid(id_valid), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_dst(id_dst), .id_is_branch(id_is_branch), .id_src(id_src),
        .id_src_used(id_src_used), .fwd_sel(fwd_sel), .stall(stall),
        .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        pipe_hold = 0; flush = 0; id_valid = 0; id_regwrite = 0; id_memread = 0;
        id_dst = '0; id_is_branch = 0; id_src = '0; id_src_used = '0;
    endtask

    task automatic drain();
        set_idle();
        repeat (3) cyc();
    endtask

    task automatic issue_wr(input logic [AW-1:0] d, input logic ld);
        set_idle();
        id_valid = 1; id_regwrite = 1; id_memread = ld; id_dst = d;
    endtask

    task automatic issue_br(input logic [AW-1:0] s0, input logic [AW-1:0] s1, input logic [1:0] used);
        set_idle();
        id_valid = 1; id_is_branch = 1; id_src = {s1, s0}; id_src_used = used;
    endtask

    initial begin
        set_idle();
        rst_n = 0;
        #12;
        check("reset_stall", stall, 0);
        check("reset_sel", fwd_sel, 0);
        check("reset_scnt", stall_cnt, 0);
        check("reset_fcnt", fwd_cnt, 0);
        rst_n = 1;

        // ALU producer in EX: one stall then sel=2
        issue_wr(3, 0); cyc();
        issue_br(3, 4, 2'b11); #1;
        check("alu_stall", stall, 1);
        check("alu_stall_sel", fwd_sel, 0);
        cyc();
        check("alu_fwd_stall", stall, 0);
        check("alu_fwd_sel", fwd_sel, 4'b0010);
        cyc(); set_idle(); #1;
        check("alu_scnt", stall_cnt, 1);
        check("alu_fcnt", fwd_cnt, 1);

        // Load in EX: two stalls then sel=3, r0 never forwards
        drain();
        issue_wr(5, 1); cyc();
        issue_br(5, 0, 2'b11); #1;
        check("ld_stall1", stall, 1);
        cyc();
        check("ld_stall2", stall, 1);
        cyc();
        check("ld_fwd_stall", stall, 0);
        check("ld_fwd_sel", fwd_sel, 4'b0011);
        cyc(); set_idle(); #1;
        check("ld_scnt", stall_cnt, 3);
        check("ld_fcnt", fwd_cnt, 2);

        // Two sources forwarding from different stages at once
        drain();
        issue_wr(7, 1); cyc();
        issue_wr(6, 0); cyc();
        set_idle(); cyc();
        issue_br(6, 7, 2'b11); #1;
        check("dual_stall", stall, 0);
        check("dual_sel", fwd_sel, 4'b1110);
        cyc(); set_idle(); #1;
        check("dual_fcnt", fwd_cnt, 3);

        // Nearest producer wins
        drain();
        issue_wr(8, 0); cyc();
        issue_wr(8, 0); cyc();
        set_idle(); cyc();
        issue_br(8, 8, 2'b11); #1;
        check("near_stall", stall, 0);
        check("near_sel", fwd_sel, 4'b1010);
        cyc(); set_idle(); #1;
        check("near_fcnt", fwd_cnt, 4);

        // pipe_hold freezes scoreboard and counters
        drain();
        issue_wr(9, 1); cyc();
        issue_br(9, 0, 2'b01); pipe_hold = 1; #1;
        check("hold_stall0", stall, 1);
        repeat (3) cyc();
        check("hold_stall3", stall, 1);
        check("hold_scnt", stall_cnt, 3);
        check("hold_sel", fwd_sel, 0);
        pipe_hold = 0; #1;
        check("rel_stall1", stall, 1);
        cyc();
        check("rel_stall2", stall, 1);
        check("rel_scnt1", stall_cnt, 4);
        cyc();
        check("rel_fwd_stall", stall, 0);
        check("rel_sel", fwd_sel, 4'b0011);
        check("rel_scnt2", stall_cnt, 5);
        cyc(); set_idle(); #1;
        check("rel_fcnt", fwd_cnt, 5);

        // Flush beats a hazard; a flushed writer enters as a bubble
        drain();
        issue_wr(10, 1); cyc();
        issue_br(10, 0, 2'b01); flush = 1; #1;
        check("flush_stall", stall, 0);
        check("flush_sel", fwd_sel, 0);
        flush = 0; #1;
        check("noflush_stall", stall, 1);
        drain();
        issue_wr(11, 0); flush = 1; cyc();
        issue_br(11, 0, 2'b01); #1;
        check("flushwr_stall", stall, 0);
        check("flushwr_sel", fwd_sel, 0);
        set_idle(); #1;
        check("flush_scnt", stall_cnt, 5);

        // Asynchronous reset during a stall
        drain();
        issue_wr(12, 1); cyc();
        issue_br(12, 0, 2'b01); #1;
        check("prerst_stall", stall, 1);
        rst_n = 0; #1;
        check("rst_stall", stall, 0);
        check("rst_sel", fwd_sel, 0);
        check("rst_scnt", stall_cnt, 0);
        check("rst_fcnt", fwd_cnt, 0);
        rst_n = 1; #1;
        check("postrst_stall", stall, 0);
        set_idle();

        // 18 stall cycles saturate a 4-bit counter at 15
        for (int n = 0; n < 9; n++) begin
            issue_wr(5, 1); cyc();
            issue_br(5, 0, 2'b01); cyc(); cyc();
            set_idle();
        end
        #1;
        check("sat_scnt", stall_cnt, 15);
        check("sat_fcnt", fwd_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_fwd_scoreboard.md
Name: branch_fwd_scoreboard

Overview:
- Parametrised ID-stage operand forwarding and stall unit for branch comparators in the 5-stage MIPS pipeline.
- Replaces pairwise EX_MEM/MEM_WB compares with an internal shift-register scoreboard of in-flight writers.
- Generalised in depth and source count. Each source gets its own nearest-producer forward select, so two sources can forward independently in the same cycle.
- Raises a stall when the nearest producer's result is not yet forwardable, and keeps saturating stall/forward performance counters.

Parameters:
- AW, 5, register address width
- NUM_SRC, 2, branch source operands per instruction
- DEPTH, 3, scoreboard stages past ID (index 0=EX, 1=MEM, 2=WB)
- ALU_READY, 1, first index at which a non-load result is forwardable
- LOAD_READY, 2, first index at which load data is forwardable
- SW, 2, fwd_sel width; must satisfy 2^SW > DEPTH
- CW, 16, perf counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pipe_hold  in  1  global freeze (cache miss); scoreboard does not shift
- flush  in  1  instruction in ID is squashed this cycle
- id_valid  in  1  ID holds a real instruction
- id_regwrite  in  1  ID instruction writes a register
- id_memread  in  1  ID instruction is a load
- id_dst  in  AW  ID destination register
- id_is_branch  in  1  ID instruction compares sources in ID
- id_src  in  NUM_SRC*AW  source register addresses, src i at bits [i*AW +: AW]
- id_src_used  in  NUM_SRC  source i is read by the comparator
- fwd_sel  out  NUM_SRC*SW  per-source select: 0=register file, k+1=forward from scoreboard index k
- stall  out  1  hold PC and IF/ID; insert bubble into EX
- stall_cnt  out  CW  saturating count of stall cycles
- fwd_cnt  out  CW  saturating count of cycles with any nonzero fwd_sel and no stall

Behaviour:
- Scoreboard entry e[k], k=0..DEPTH-1, holds {v, dst, ld}. Reset: all v=0, dst=0, ld=0. stall_cnt=0, fwd_cnt=0. Consequently fwd_sel=0 and stall=0 immediately after reset.
- Write condition: an entry is a writer iff v=1 and dst!=0. Bubbles and non-writing instructions enter with v=0.
- Shift on each clk edge with pipe_hold=0:
  - e[k] <= e[k-1] for k>=1.
  - e[0] <= {id_valid & id_regwrite & ~stall & ~flush, id_dst, id_memread}.
  - e[DEPTH-1] retires; the register file is written by then.
- pipe_hold=1: all entries and counters hold. stall/fwd_sel are still computed combinationally.
- Per source i (combinational, from current entries and ID inputs):
  - Match k: e[k] is a writer and e[k].dst == src_i. Address 0 never matches.
  - Nearest producer = smallest matching k. Older matches are ignored.
  - ready = (k >= LOAD_READY) if e[k].ld, else (k >= ALU_READY).
  - Requires id_is_branch=1, id_valid=1, id_src_used[i]=1 and a match. Otherwise fwd_sel_i=0 and there is no stall contribution.
  - If ready: fwd_sel_i = k+1. If not ready: stall contribution 1 and fwd_sel_i=0.
- stall = OR of all contributions, forced 0 when flush=1.
- While stall=1, every fwd_sel output is 0.
- Default latencies:
  - ALU producer in EX: 1 stall cycle, then sel=2.
  - Load producer in EX: 2 stall cycles, then sel=3.
  - Load producer in MEM: 1 stall cycle, then sel=3.
- Counters update on clocked, non-held cycles and saturate at all-ones without wrapping:
  - stall_cnt increments when stall=1.
  - fwd_cnt increments when stall=0 and any fwd_sel!=0.
- Simultaneous flush and hazard: flush wins, stall=0, and a bubble enters.
- Reset mid-stall: scoreboard cleared asynchronously, so stall drops immediately and counters clear.

Test Plan:
- add r3 enters EX (e[0]={1,3,0}), beq r3,r4 in ID: stall=1 for 1 cycle, then fwd_sel[0]=2, fwd_sel[1]=0. stall_cnt=1, fwd_cnt=1.
- lw r5 in EX, beq r5,r0: stall for 2 consecutive cycles, then src0 sel=3. src1 (r0) stays 0.
- e[1]=add r6 (dst 6), e[2]=lw r7 (dst 7), beq r6,r7: no stall, same cycle src0 sel=2 and src1 sel=3 (both sources forward at once).
- e[1] and e[2] both write r8, beq r8,r8: both sources sel=2 (nearest producer wins).
- Load r9 in EX, beq r9 with pipe_hold=1 for 3 cycles: stall stays 1, entries frozen, stall_cnt unchanged. Release: 2 more stall cycles, then sel=3.
- Assert rst_n=0 during a stall: stall and fwd_sel are 0 asynchronously and counters are 0. stall_cnt preloaded near all-ones then stalled: holds at all-ones.
